// File: rtl/text_pkg.sv
// Shared definitions for the text buffer writer.
//   text_op_t  : command opcodes accepted on cmd_op
//   state_t    : controller states
//   CHAR_ZERO  : ASCII '0', base for decimal digits
//   MSG_COUNT  : number of valid message ids
//   MSG_TABLE  : fixed messages, left-aligned, NUL padded to 16 bytes
package text_pkg;

    typedef enum logic [1:0] {
        OP_MSG   = 2'd0,
        OP_NUM   = 2'd1,
        OP_CLEAR = 2'd2,
        OP_NOP   = 2'd3
    } text_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] CHAR_ZERO = 8'h30;
    localparam logic [7:0] MSG_COUNT = 8'd4;

    // Element [id][0] is the first character of message id.
    localparam logic [0:3][0:15][7:0] MSG_TABLE = {
        {"START",         88'h0},
        {"PLAYER 1 WINS", 24'h0},
        {"PLAYER 2 WINS", 24'h0},
        {"PRESS ENTER",   40'h0}
    };

endpackage

// File: rtl/msg_rom.sv
// Combinational message ROM.
//   id  : message id (ids >= MSG_COUNT are invalid)
//   idx : character index within the message
//   chr : ASCII character, 8'h00 past the string end or for an invalid id
module msg_rom
    import text_pkg::*;
(
    input  logic [7:0] id,
    input  logic [3:0] idx,
    output logic [7:0] chr
);

    // Table lookup; invalid ids read as an empty string.
    always_comb begin
        chr = 8'h00;
        if (id < MSG_COUNT) begin
            chr = MSG_TABLE[id[1:0]][idx];
        end else begin
            chr = 8'h00;
        end
    end

endmodule

// File: rtl/text_buf_writer.sv
// Command-driven writer for the 16x16 on-screen character buffer.
//   clk, rst          : pixel clock, asynchronous active-low reset
//   vblnk             : write gate; characters are only written in vertical blanking
//   cmd_valid/ready   : one-command handshake, ready only in IDLE
//   cmd_op/row/col/arg: command (MSG id, NUM value, CLEAR, no-op)
//   buf_we/addr/data  : registered write port, addr = {row, col}
//   busy              : command in progress (WRITE or DONE)
//   done              : one-cycle completion pulse
module text_buf_writer
    import text_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR = 8'h20,
    parameter int         MAX_LEN   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_row,
    input  logic [3:0] cmd_col,
    input  logic [7:0] cmd_arg,
    output logic       buf_we,
    output logic [7:0] buf_addr,
    output logic [7:0] buf_data,
    output logic       busy,
    output logic       done
);

    state_t     state_q, state_d;
    text_op_t   op_q, op_d;
    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;
    logic [7:0] arg_q, arg_d;
    logic [8:0] idx_q, idx_d;
    logic       buf_we_q, buf_we_d;
    logic [7:0] buf_addr_q, buf_addr_d;
    logic [7:0] buf_data_q, buf_data_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;

    logic [7:0] rom_chr_s;
    logic [6:0] num_v_s;
    logic [3:0] num_tens_s;
    logic [3:0] num_ones_s;
    logic       have_char_s;
    logic [7:0] char_s;

    msg_rom u_msg_rom (
        .id  (arg_q),
        .idx (idx_q[3:0]),
        .chr (rom_chr_s)
    );

    // Decimal digits of the saturated NUM value.
    always_comb begin
        num_v_s    = (arg_q > 8'd99) ? 7'd99 : arg_q[6:0];
        num_tens_s = 4'(num_v_s / 7'd10);
        num_ones_s = 4'(num_v_s % 7'd10);
    end

    // Character for the current index and whether one remains to be written.
    always_comb begin
        have_char_s = 1'b0;
        char_s      = 8'h00;
        case (op_q)
            OP_MSG: begin
                // The ROM index is only meaningful while below MAX_LEN.
                have_char_s = (idx_q < 9'(MAX_LEN)) && (rom_chr_s != 8'h00);
                char_s      = rom_chr_s;
            end
            OP_NUM: begin
                have_char_s = (idx_q < 9'd2);
                if (idx_q == 9'd0) begin
                    char_s = CHAR_ZERO + {4'd0, num_tens_s};
                end else begin
                    char_s = CHAR_ZERO + {4'd0, num_ones_s};
                end
            end
            OP_CLEAR: begin
                have_char_s = (idx_q[8] == 1'b0);
                char_s      = FILL_CHAR;
            end
            default: begin
                have_char_s = 1'b0;
                char_s      = 8'h00;
            end
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        row_d      = row_q;
        col_d      = col_q;
        arg_d      = arg_q;
        idx_d      = idx_q;
        buf_we_d   = 1'b0;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = text_op_t'(cmd_op);
                    arg_d   = cmd_arg;
                    idx_d   = 9'd0;
                    state_d = ST_WRITE;
                    // CLEAR walks the whole buffer from address 0x00.
                    if (text_op_t'(cmd_op) == OP_CLEAR) begin
                        row_d = 4'd0;
                        col_d = 4'd0;
                    end else begin
                        row_d = cmd_row;
                        col_d = cmd_col;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (!have_char_s) begin
                    state_d = ST_DONE;
                end else if (vblnk) begin
                    buf_we_d       = 1'b1;
                    buf_addr_d     = {row_q, col_q};
                    buf_data_d     = char_s;
                    idx_d          = idx_q + 9'd1;
                    // Column carry into row; both wrap at 15.
                    {row_d, col_d} = {row_q, col_q} + 8'd1;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            arg_q      <= 8'd0;
            idx_q      <= 9'd0;
            buf_we_q   <= 1'b0;
            buf_addr_q <= 8'd0;
            buf_data_q <= 8'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            row_q      <= row_d;
            col_q      <= col_d;
            arg_q      <= arg_d;
            idx_q      <= idx_d;
            buf_we_q   <= buf_we_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign buf_we    = buf_we_q;
    assign buf_addr  = buf_addr_q;
    assign buf_data  = buf_data_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule
